// File: rtl/alu_core_if.sv
// Operand/opcode and registered result/flag bundle for alu_core.
// The master drives operands and the opcode; the slave (the ALU) returns the result and flags.
interface alu_core_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] operand1;
  logic [WIDTH-1:0] operand2;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             negative;
  logic             carry;
  logic             overflow;

  modport master (
    output operand1, operand2, opcode,
    input  result, zero, negative, carry, overflow
  );

  modport slave (
    input  operand1, operand2, opcode,
    output result, zero, negative, carry, overflow
  );
endinterface

// File: rtl/alu_core.sv
// Integer ALU with registered result and zero/negative/carry/overflow flags (one-cycle latency).
// Optional macro ALU_MUL_EN enables opcode 1100 as the low WIDTH bits of unsigned A*B.
module alu_core #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst,
  alu_core_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0011;
  localparam logic [3:0] OP_OR   = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_SLL  = 4'b0110;
  localparam logic [3:0] OP_SRL  = 4'b0111;
  localparam logic [3:0] OP_SRA  = 4'b1000;
  localparam logic [3:0] OP_SLT  = 4'b1001;
  localparam logic [3:0] OP_SLTU = 4'b1010;
  localparam logic [3:0] OP_NOR  = 4'b1011;
  localparam logic [3:0] OP_MUL  = 4'b1100;

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] res_next;
  logic             carry_next;
  logic             ovf_next;

  assign a     = bus.operand1;
  assign b     = bus.operand2;
  assign shamt = b[SHW-1:0];
  assign sum   = {1'b0, a} + {1'b0, b};
  // Bit WIDTH of the difference is the borrow, so carry for SUB is its inverse.
  assign diff  = {1'b0, a} - {1'b0, b};

  always_comb begin
    res_next   = '0;
    carry_next = 1'b0;
    ovf_next   = 1'b0;
    case (bus.opcode)
      OP_NOP:  res_next = '0;
      OP_ADD: begin
        res_next   = sum[WIDTH-1:0];
        carry_next = sum[WIDTH];
        ovf_next   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        res_next   = diff[WIDTH-1:0];
        carry_next = ~diff[WIDTH];
        ovf_next   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  res_next = a & b;
      OP_OR:   res_next = a | b;
      OP_XOR:  res_next = a ^ b;
      OP_SLL:  res_next = a << shamt;
      OP_SRL:  res_next = a >> shamt;
      OP_SRA:  res_next = $signed(a) >>> shamt;
      OP_SLT:  res_next = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: res_next = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_NOR:  res_next = ~(a | b);
`ifdef ALU_MUL_EN
      OP_MUL:  res_next = a * b;
`else
      OP_MUL:  res_next = '0;
`endif
      default: res_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.result   <= '0;
      bus.zero     <= 1'b1;
      bus.negative <= 1'b0;
      bus.carry    <= 1'b0;
      bus.overflow <= 1'b0;
    end else begin
      bus.result   <= res_next;
      bus.zero     <= (res_next == '0);
      bus.negative <= res_next[WIDTH-1];
      bus.carry    <= carry_next;
      bus.overflow <= ovf_next;
    end
  end
endmodule

// File: tb/tb_alu_core.sv
// Directed self-checking bench for alu_core; each vector carries a hand-computed result and
// flag nibble {zero, negative, carry, overflow}.
module tb_alu_core;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  flg;
  } vec_t;

  alu_core_if #(.WIDTH(32)) bus ();

  alu_core #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled 1ns after the rising edge.
  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.opcode   = op;
    bus.operand1 = a;
    bus.operand2 = b;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst          = 1'b1;
    bus.opcode   = 4'b0001;
    bus.operand1 = 32'd3;
    bus.operand2 = 32'd4;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.result, bus.zero, bus.negative, bus.carry, bus.overflow} !== {32'h0, 4'b1000}) begin
      failures++;
      $display("[TB] FAIL reset: got res=%h zncv=%b%b%b%b want res=00000000 zncv=1000",
               bus.result, bus.zero, bus.negative, bus.carry, bus.overflow);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic_ops();
    vec_t v[7];
    v[0] = {4'b0001, 32'd10, 32'd5, 32'd15,  4'b0000};
    v[1] = {4'b0010, 32'd10, 32'd5, 32'd5,   4'b0010};
    v[2] = {4'b0011, 32'd10, 32'd5, 32'd0,   4'b1000};
    v[3] = {4'b0100, 32'd10, 32'd5, 32'd15,  4'b0000};
    v[4] = {4'b0101, 32'd10, 32'd5, 32'd15,  4'b0000};
    v[5] = {4'b0110, 32'd10, 32'd5, 32'd320, 4'b0000};
    v[6] = {4'b0111, 32'd10, 32'd5, 32'd0,   4'b1000};
    for (int i = 0; i < 7; i++) begin
      drive(v[i].op, v[i].a, v[i].b);
      checks++;
      if ({bus.result, bus.zero, bus.negative, bus.carry, bus.overflow} !== {v[i].res, v[i].flg}) begin
        failures++;
        $display("[TB] FAIL basic_ops[%0d] op=%b: got res=%h zncv=%b%b%b%b want res=%h zncv=%b",
                 i, v[i].op, bus.result, bus.zero, bus.negative, bus.carry, bus.overflow,
                 v[i].res, v[i].flg);
      end
    end
  endtask

  task automatic test_arith_flags();
    vec_t v[5];
    v[0] = {4'b0001, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b0101};
    v[1] = {4'b0001, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b1010};
    v[2] = {4'b0010, 32'h00000005, 32'h0000000A, 32'hFFFFFFFB, 4'b0100};
    v[3] = {4'b0010, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0011};
    v[4] = {4'b1011, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 4'b0100};
    for (int i = 0; i < 5; i++) begin
      drive(v[i].op, v[i].a, v[i].b);
      checks++;
      if ({bus.result, bus.zero, bus.negative, bus.carry, bus.overflow} !== {v[i].res, v[i].flg}) begin
        failures++;
        $display("[TB] FAIL arith_flags[%0d] op=%b: got res=%h zncv=%b%b%b%b want res=%h zncv=%b",
                 i, v[i].op, bus.result, bus.zero, bus.negative, bus.carry, bus.overflow,
                 v[i].res, v[i].flg);
      end
    end
  endtask

  task automatic test_shift_compare();
    vec_t v[8];
    v[0] = {4'b1000, 32'h80000000, 32'h00000004, 32'hF8000000, 4'b0100};
    v[1] = {4'b0111, 32'h80000000, 32'h00000004, 32'h08000000, 4'b0000};
    v[2] = {4'b1001, 32'h80000000, 32'h00000004, 32'h00000001, 4'b0000};
    v[3] = {4'b1010, 32'h80000000, 32'h00000004, 32'h00000000, 4'b1000};
    v[4] = {4'b1001, 32'h00000004, 32'h80000000, 32'h00000000, 4'b1000};
    v[5] = {4'b1010, 32'h00000004, 32'h80000000, 32'h00000001, 4'b0000};
    v[6] = {4'b0110, 32'h00001234, 32'h00000020, 32'h00001234, 4'b0000};
    v[7] = {4'b1000, 32'h80000000, 32'hFFFFFFE1, 32'hC0000000, 4'b0100};
    for (int i = 0; i < 8; i++) begin
      drive(v[i].op, v[i].a, v[i].b);
      checks++;
      if ({bus.result, bus.zero, bus.negative, bus.carry, bus.overflow} !== {v[i].res, v[i].flg}) begin
        failures++;
        $display("[TB] FAIL shift_compare[%0d] op=%b: got res=%h zncv=%b%b%b%b want res=%h zncv=%b",
                 i, v[i].op, bus.result, bus.zero, bus.negative, bus.carry, bus.overflow,
                 v[i].res, v[i].flg);
      end
    end
  endtask

  task automatic test_reserved_mul();
    vec_t v[4];
    v[0] = {4'b1111, 32'h12345678, 32'h00000003, 32'h00000000, 4'b1000};
    v[1] = {4'b1101, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 4'b1000};
    v[2] = {4'b0000, 32'h00000001, 32'h00000001, 32'h00000000, 4'b1000};
`ifdef ALU_MUL_EN
    v[3] = {4'b1100, 32'h00000006, 32'h00000007, 32'h0000002A, 4'b0000};
`else
    v[3] = {4'b1100, 32'h00000006, 32'h00000007, 32'h00000000, 4'b1000};
`endif
    for (int i = 0; i < 4; i++) begin
      drive(v[i].op, v[i].a, v[i].b);
      checks++;
      if ({bus.result, bus.zero, bus.negative, bus.carry, bus.overflow} !== {v[i].res, v[i].flg}) begin
        failures++;
        $display("[TB] FAIL reserved_mul[%0d] op=%b: got res=%h zncv=%b%b%b%b want res=%h zncv=%b",
                 i, v[i].op, bus.result, bus.zero, bus.negative, bus.carry, bus.overflow,
                 v[i].res, v[i].flg);
      end
    end
  endtask

  // An op presented alongside rst must be discarded, and the stream resumes right after.
  task automatic test_reset_midstream();
    drive(4'b0001, 32'd20, 32'd22);
    checks++;
    if (bus.result !== 32'd42) begin
      failures++;
      $display("[TB] FAIL midstream_pre: got res=%h want res=0000002a", bus.result);
    end
    @(negedge clk);
    rst          = 1'b1;
    bus.opcode   = 4'b1100;
    bus.operand1 = 32'd6;
    bus.operand2 = 32'd7;
    @(posedge clk);
    #1;
    checks++;
    if ({bus.result, bus.zero, bus.negative, bus.carry, bus.overflow} !== {32'h0, 4'b1000}) begin
      failures++;
      $display("[TB] FAIL midstream_rst: got res=%h zncv=%b%b%b%b want res=00000000 zncv=1000",
               bus.result, bus.zero, bus.negative, bus.carry, bus.overflow);
    end
    @(negedge clk);
    rst = 1'b0;
    drive(4'b0010, 32'd100, 32'd1);
    checks++;
    if ({bus.result, bus.zero, bus.negative, bus.carry, bus.overflow} !== {32'd99, 4'b0010}) begin
      failures++;
      $display("[TB] FAIL midstream_post: got res=%h zncv=%b%b%b%b want res=00000063 zncv=0010",
               bus.result, bus.zero, bus.negative, bus.carry, bus.overflow);
    end
  endtask

  // Consecutive cycles: each output must belong to the op of the immediately preceding edge.
  task automatic test_back_to_back();
    logic [31:0] exp_res [4];
    logic [3:0]  ops     [4];
    logic [31:0] as      [4];
    logic [31:0] bs      [4];
    ops[0] = 4'b0001; as[0] = 32'd1;        bs[0] = 32'd2;  exp_res[0] = 32'd3;
    ops[1] = 4'b0110; as[1] = 32'd1;        bs[1] = 32'd31; exp_res[1] = 32'h80000000;
    ops[2] = 4'b0101; as[2] = 32'hFF00FF00; bs[2] = 32'h0FF00FF0; exp_res[2] = 32'hF0F0F0F0;
    ops[3] = 4'b0011; as[3] = 32'hFF00FF00; bs[3] = 32'h0FF00FF0; exp_res[3] = 32'h0F000F00;
    for (int i = 0; i < 4; i++) begin
      drive(ops[i], as[i], bs[i]);
      checks++;
      if (bus.result !== exp_res[i]) begin
        failures++;
        $display("[TB] FAIL back_to_back[%0d]: got res=%h want res=%h", i, bus.result, exp_res[i]);
      end
    end
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    rst          = 1'b1;
    bus.opcode   = 4'b0000;
    bus.operand1 = '0;
    bus.operand2 = '0;
    test_reset();
    test_basic_ops();
    test_arith_flags();
    test_shift_compare();
    test_reserved_mul();
    test_reset_midstream();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
